// File: rtl/wb_port_if.sv
// Bundle of host command/response and Wishbone pipelined bus signals for one
// RAM port. The master modport is the initiator's view; slave is everything
// on the other side (host plus responder).
interface wb_port_if #(
   parameter int A_WIDTH = 8
);
   // host command channel
   logic               cmd_valid;
   logic               cmd_ready;
   logic [A_WIDTH:0]   cmd_addr;
   logic [3:0]         cmd_we;
   logic [31:0]        cmd_data;

   // Wishbone pipelined request/response
   logic               wb_stb_o;
   logic [A_WIDTH:0]   wb_addr_o;
   logic [3:0]         wb_we_o;
   logic [31:0]        wb_data_o;
   logic               wb_stall_i;
   logic               wb_ack_i;
   logic [31:0]        wb_data_i;

   // host response channel and status
   logic               rsp_valid;
   logic               rsp_ready;
   logic [31:0]        rsp_data;
   logic               rsp_err;
   logic [7:0]         err_count;

   modport master (
      input  cmd_valid, cmd_addr, cmd_we, cmd_data,
      output cmd_ready,
      output wb_stb_o, wb_addr_o, wb_we_o, wb_data_o,
      input  wb_stall_i, wb_ack_i, wb_data_i,
      output rsp_valid, rsp_data, rsp_err, err_count,
      input  rsp_ready
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_we, cmd_data,
      input  cmd_ready,
      input  wb_stb_o, wb_addr_o, wb_we_o, wb_data_o,
      output wb_stall_i, wb_ack_i, wb_data_i,
      input  rsp_valid, rsp_data, rsp_err, err_count,
      output rsp_ready
   );
endinterface

// File: rtl/wb_port_master.sv
// Single-outstanding Wishbone pipelined initiator for one port of the
// dual-port RAM. One command in, one strobe out, one response back; a cycle
// counter aborts the transaction if the responder never acknowledges.
module wb_port_master #(
   parameter int A_WIDTH = 8,
   parameter int TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         rst,
   wb_port_if.master    bus
);

   // Counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_REQ      = 2'd1;
   localparam logic [1:0] S_WAIT_ACK = 2'd2;
   localparam logic [1:0] S_RESP     = 2'd3;

   logic [1:0]       state_q,    state_d;
   logic [CW-1:0]    cnt_q,      cnt_d;
   logic             stb_q,      stb_d;
   logic [A_WIDTH:0] addr_q,     addr_d;
   logic [3:0]       we_q,       we_d;
   logic [31:0]      wdata_q,    wdata_d;
   logic [31:0]      rsp_data_q, rsp_data_d;
   logic             rsp_err_q,  rsp_err_d;
   logic [7:0]       err_cnt_q,  err_cnt_d;

   logic             timeout_hit;
   logic             stray_ack;
   logic             cnt_expired;

   assign cnt_expired = (cnt_q == CNT_LAST);

   // Next-state logic: FSM, bus request registers, response capture, error count
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      stb_d       = stb_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      err_cnt_d   = err_cnt_q;
      timeout_hit = 1'b0;
      stray_ack   = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Any ack here belongs to no request of ours.
            stray_ack = bus.wb_ack_i;
            if (bus.cmd_valid) begin
               addr_d  = bus.cmd_addr;
               we_d    = bus.cmd_we;
               wdata_d = bus.cmd_data;
               stb_d   = 1'b1;
               state_d = S_REQ;
            end
         end

         S_REQ: begin
            cnt_d = cnt_q + CNT_ONE;
            // An ack only counts once the strobe is actually taken (no stall);
            // when it lands in that same cycle it also beats the timeout.
            if (!bus.wb_stall_i && bus.wb_ack_i) begin
               stb_d      = 1'b0;
               rsp_data_d = bus.wb_data_i;
               rsp_err_d  = 1'b0;
               state_d    = S_RESP;
            end else if (cnt_expired) begin
               stb_d       = 1'b0;
               rsp_data_d  = 32'h0;
               rsp_err_d   = 1'b1;
               timeout_hit = 1'b1;
               state_d     = S_RESP;
            end else if (!bus.wb_stall_i) begin
               stb_d   = 1'b0;
               state_d = S_WAIT_ACK;
            end
         end

         S_WAIT_ACK: begin
            cnt_d = cnt_q + CNT_ONE;
            // Data is captured for writes too: the responder returns the
            // post-write word.
            if (bus.wb_ack_i) begin
               rsp_data_d = bus.wb_data_i;
               rsp_err_d  = 1'b0;
               state_d    = S_RESP;
            end else if (cnt_expired) begin
               rsp_data_d  = 32'h0;
               rsp_err_d   = 1'b1;
               timeout_hit = 1'b1;
               state_d     = S_RESP;
            end
         end

         S_RESP: begin
            stray_ack = bus.wb_ack_i;
            if (bus.rsp_ready) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
            stb_d   = 1'b0;
            cnt_d   = '0;
         end
      endcase

      // One increment per cycle at most, saturating at 255.
      if ((timeout_hit || stray_ack) && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         stb_q      <= 1'b0;
         addr_q     <= '0;
         we_q       <= 4'h0;
         wdata_q    <= 32'h0;
         rsp_data_q <= 32'h0;
         rsp_err_q  <= 1'b0;
         err_cnt_q  <= 8'h0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         stb_q      <= stb_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign bus.cmd_ready = (state_q == S_IDLE);
   assign bus.rsp_valid = (state_q == S_RESP);
   assign bus.wb_stb_o  = stb_q;
   assign bus.wb_addr_o = addr_q;
   assign bus.wb_we_o   = we_q;
   assign bus.wb_data_o = wdata_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.err_count = err_cnt_q;

endmodule
